// File: rtl/code_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : code_pkg
//  Description : Shared constants and types for the code memory loader.
//                CODE_ADDR_W  - code memory address width
//                CODE_WORD_W  - code memory word width
//                LOADER_SYNC  - frame start marker byte
//                loader_state_e - loader frame-parser states
//  Revision    : 1.0 - initial release
// ============================================================================
package code_pkg;

   localparam int         CODE_ADDR_W = 6;
   localparam int         CODE_WORD_W = 16;
   localparam logic [7:0] LOADER_SYNC = 8'hA5;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ADDR    = 3'd1,
      COUNT   = 3'd2,
      DATA_HI = 3'd3,
      DATA_LO = 3'd4,
      CSUM    = 3'd5,
      FIN     = 3'd6
   } loader_state_e;

endpackage
`default_nettype wire

// File: rtl/code_loader.sv
`default_nettype none
// ============================================================================
//  Module      : code_loader
//  Description : Byte-stream program loader. Parses frames of the form
//                SYNC, start_addr, word_count, 2*N data bytes [, checksum],
//                packs data bytes MSB-first into 16-bit words and writes them
//                to consecutive (wrapping) code memory addresses while holding
//                the CPU.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                in_data/in_valid/in_ready - byte input handshake
//                abort           - abandon the current frame (sets err)
//                wr_en/wr_addr/wr_data - code memory write port (1-cycle strobe)
//                cpu_hold        - high while a frame is in progress
//                done            - one-cycle pulse on successful load
//                err             - sticky error, cleared by the next SYNC
//  Config      : `define CODE_LOADER_CHECKSUM_EN to expect a trailing XOR
//                checksum byte (XOR of addr, count and all data bytes).
//  Revision    : 1.0 - initial release
// ============================================================================
module code_loader
   import code_pkg::*;
#(
   parameter int         ADDR_W    = CODE_ADDR_W,
   parameter logic [7:0] SYNC_BYTE = LOADER_SYNC
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [7:0]             in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   abort,
   output logic                   wr_en,
   output logic [ADDR_W-1:0]      wr_addr,
   output logic [CODE_WORD_W-1:0] wr_data,
   output logic                   cpu_hold,
   output logic                   done,
   output logic                   err
);

   loader_state_e             r_state;
   logic [ADDR_W-1:0]         r_addr_ptr;
   // One extra bit so a count byte of 0 can stand for a full 2**ADDR_W words.
   logic [ADDR_W:0]           r_remaining;
   logic [7:0]                r_hi;
   logic                      r_wr_en;
   logic [ADDR_W-1:0]         r_wr_addr;
   logic [CODE_WORD_W-1:0]    r_wr_data;
   logic                      r_err;
`ifdef CODE_LOADER_CHECKSUM_EN
   logic [7:0]                r_csum;
`endif

   logic                      w_take;
   logic [ADDR_W:0]           w_count_load;

   // abort suppresses byte acceptance in the same cycle.
   assign w_take       = in_valid && in_ready && !abort;
   // Only the low ADDR_W bits of the count byte are meaningful; 0 means a full
   // memory's worth of words.
   assign w_count_load = (in_data[ADDR_W-1:0] == '0) ?
                         {1'b1, {ADDR_W{1'b0}}} :
                         {1'b0, in_data[ADDR_W-1:0]};

   assign in_ready = !rst && (r_state != FIN);
   assign cpu_hold = (r_state != IDLE) && (r_state != FIN);
   assign done     = (r_state == FIN) && !r_err && !abort;
   assign wr_en    = r_wr_en;
   assign wr_addr  = r_wr_addr;
   assign wr_data  = r_wr_data;
   assign err      = r_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_addr_ptr  <= '0;
         r_remaining <= '0;
         r_hi        <= '0;
         r_wr_en     <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_err       <= 1'b0;
`ifdef CODE_LOADER_CHECKSUM_EN
         r_csum      <= '0;
`endif
      end else begin
         r_wr_en <= 1'b0;
         if (abort && (r_state != IDLE)) begin
            // A strobe already on wr_en this cycle is unaffected.
            r_state <= IDLE;
            r_err   <= 1'b1;
         end else begin
            case (r_state)
               IDLE: begin
                  if (w_take && (in_data == SYNC_BYTE)) begin
                     r_state <= ADDR;
                     r_err   <= 1'b0;
                  end
               end
               ADDR: begin
                  if (w_take) begin
                     r_addr_ptr <= in_data[ADDR_W-1:0];
`ifdef CODE_LOADER_CHECKSUM_EN
                     r_csum     <= in_data;
`endif
                     r_state    <= COUNT;
                  end
               end
               COUNT: begin
                  if (w_take) begin
                     r_remaining <= w_count_load;
`ifdef CODE_LOADER_CHECKSUM_EN
                     r_csum      <= r_csum ^ in_data;
`endif
                     r_state     <= DATA_HI;
                  end
               end
               DATA_HI: begin
                  if (w_take) begin
                     r_hi    <= in_data;
`ifdef CODE_LOADER_CHECKSUM_EN
                     r_csum  <= r_csum ^ in_data;
`endif
                     r_state <= DATA_LO;
                  end
               end
               DATA_LO: begin
                  if (w_take) begin
                     r_wr_en     <= 1'b1;
                     r_wr_addr   <= r_addr_ptr;
                     r_wr_data   <= {r_hi, in_data};
                     r_addr_ptr  <= r_addr_ptr + 1'b1;
                     r_remaining <= r_remaining - 1'b1;
`ifdef CODE_LOADER_CHECKSUM_EN
                     r_csum      <= r_csum ^ in_data;
`endif
                     if (r_remaining == {{ADDR_W{1'b0}}, 1'b1}) begin
`ifdef CODE_LOADER_CHECKSUM_EN
                        r_state <= CSUM;
`else
                        r_state <= FIN;
`endif
                     end else begin
                        r_state <= DATA_HI;
                     end
                  end
               end
`ifdef CODE_LOADER_CHECKSUM_EN
               CSUM: begin
                  if (w_take) begin
                     // Setting err here suppresses done in the FIN cycle.
                     if (in_data != r_csum) begin
                        r_err <= 1'b1;
                     end
                     r_state <= FIN;
                  end
               end
`endif
               FIN: begin
                  r_state <= IDLE;
               end
               default: begin
                  r_state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_code_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_code_loader
//  Description : Directed self-checking bench for code_loader. Builds frames,
//                records write strobes and done pulses, and compares them with
//                hand-computed expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_code_loader;

   logic        clk;
   logic        rst;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        abort;
   logic        wr_en;
   logic [5:0]  wr_addr;
   logic [15:0] wr_data;
   logic        cpu_hold;
   logic        done;
   logic        err;

   int vectors;
   int miscompares;
   int done_cnt;
   int hold_at_done;
   int d0;
   logic [5:0]  wa_q[$];
   logic [15:0] wd_q[$];
   logic [7:0]  fr[$];

   code_loader dut (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .abort    (abort),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .cpu_hold (cpu_hold),
      .done     (done),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_en) begin
         wa_q.push_back(wr_addr);
         wd_q.push_back(wr_data);
      end
      if (done) begin
         done_cnt++;
         if (cpu_hold) hold_at_done++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Present one byte and hold it until accepted; returns at posedge+1.
   task automatic send(input logic [7:0] b);
      bit ok;
      int guard;
      ok = 1'b0;
      guard = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (!ok && guard < 50) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         guard++;
      end
      if (!ok) begin
         vectors++;
         miscompares++;
         $error("FAIL send_timeout: byte=%0h not accepted, required acceptance", b);
      end
   endtask

   task automatic send_bp(input logic [7:0] b);
      in_valid = 1'b0;
      cycles($urandom_range(2, 0));
      send(b);
   endtask

   // Sends SYNC, then fr[], then (if enabled) the XOR checksum ^ corrupt.
   task automatic send_frame(input bit bp, input logic [7:0] corrupt);
      logic [7:0] cs;
      cs = 8'h00;
      if (bp) send_bp(8'hA5); else send(8'hA5);
      chk("hold_after_sync", {31'd0, cpu_hold}, 32'd1);
      chk("err_cleared_by_sync", {31'd0, err}, 32'd0);
      foreach (fr[i]) begin
         cs = cs ^ fr[i];
         if (bp) send_bp(fr[i]); else send(fr[i]);
      end
`ifdef CODE_LOADER_CHECKSUM_EN
      if (bp) send_bp(cs ^ corrupt); else send(cs ^ corrupt);
`else
      cs = cs ^ corrupt;
`endif
      in_valid = 1'b0;
      cycles(3);
   endtask

   initial begin
      vectors      = 0;
      miscompares  = 0;
      done_cnt     = 0;
      hold_at_done = 0;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      abort    = 1'b0;
      cycles(3);

      // ---- reset state ----
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_wr_en",    {31'd0, wr_en},    32'd0);
      chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
      chk("rst_done",     {31'd0, done},     32'd0);
      chk("rst_err",      {31'd0, err},      32'd0);
      chk("rst_wr_addr",  {26'd0, wr_addr},  32'd0);
      chk("rst_wr_data",  {16'd0, wr_data},  32'd0);
      rst = 1'b0;
      cycles(1);
      chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

      // ---- basic load: A5 20 02 30 00 8C 08 [96] ----
      wa_q.delete(); wd_q.delete(); d0 = done_cnt;
      fr = '{8'h20, 8'h02, 8'h30, 8'h00, 8'h8C, 8'h08};
      send_frame(1'b0, 8'h00);
      chk("basic_nwr",   wa_q.size(), 32'd2);
      if (wa_q.size() == 2) begin
         chk("basic_a0", {26'd0, wa_q[0]}, 32'h20);
         chk("basic_d0", {16'd0, wd_q[0]}, 32'h3000);
         chk("basic_a1", {26'd0, wa_q[1]}, 32'h21);
         chk("basic_d1", {16'd0, wd_q[1]}, 32'h8C08);
      end
      chk("basic_done",   done_cnt - d0, 32'd1);
      chk("basic_hold_fin", hold_at_done, 32'd0);
      chk("basic_hold_after", {31'd0, cpu_hold}, 32'd0);
      chk("basic_err",    {31'd0, err}, 32'd0);

      // ---- wrap: A5 3F 02 11 11 22 22 ----
      wa_q.delete(); wd_q.delete(); d0 = done_cnt;
      fr = '{8'h3F, 8'h02, 8'h11, 8'h11, 8'h22, 8'h22};
      send_frame(1'b0, 8'h00);
      chk("wrap_nwr", wa_q.size(), 32'd2);
      if (wa_q.size() == 2) begin
         chk("wrap_a0", {26'd0, wa_q[0]}, 32'h3F);
         chk("wrap_d0", {16'd0, wd_q[0]}, 32'h1111);
         chk("wrap_a1", {26'd0, wa_q[1]}, 32'h00);
         chk("wrap_d1", {16'd0, wd_q[1]}, 32'h2222);
      end
      chk("wrap_done", done_cnt - d0, 32'd1);

      // ---- garbage then count 0 (64 words) ----
      wa_q.delete(); wd_q.delete(); d0 = done_cnt;
      send(8'h00);
      send(8'hFF);
      chk("garbage_hold", {31'd0, cpu_hold}, 32'd0);
      fr = '{8'h00, 8'h00};
      for (int i = 0; i < 64; i++) begin
         fr.push_back(8'(i));
         fr.push_back(8'(i) ^ 8'hC3);
      end
      send_frame(1'b0, 8'h00);
      chk("cnt0_nwr", wa_q.size(), 32'd64);
      if (wa_q.size() == 64) begin
         for (int i = 0; i < 64; i++) begin
            chk("cnt0_addr", {26'd0, wa_q[i]}, 32'(i));
            chk("cnt0_data", {16'd0, wd_q[i]}, {16'd0, 8'(i), 8'(i) ^ 8'hC3});
         end
      end
      chk("cnt0_done", done_cnt - d0, 32'd1);

`ifdef CODE_LOADER_CHECKSUM_EN
      // ---- checksum error: last byte 0x97 ----
      wa_q.delete(); wd_q.delete(); d0 = done_cnt;
      fr = '{8'h20, 8'h02, 8'h30, 8'h00, 8'h8C, 8'h08};
      send_frame(1'b0, 8'h01);
      chk("csum_nwr",  wa_q.size(), 32'd2);
      chk("csum_err",  {31'd0, err}, 32'd1);
      chk("csum_done", done_cnt - d0, 32'd0);
      chk("csum_hold", {31'd0, cpu_hold}, 32'd0);
`endif

      // ---- abort after 3rd data byte ----
      wa_q.delete(); wd_q.delete(); d0 = done_cnt;
      send(8'hA5); send(8'h10); send(8'h03);
      send(8'hAA); send(8'hBB); send(8'hCC);
      in_valid = 1'b0;
      abort    = 1'b1;
      cycles(1);
      abort    = 1'b0;
      chk("abort_hold", {31'd0, cpu_hold}, 32'd0);
      chk("abort_err",  {31'd0, err}, 32'd1);
      cycles(2);
      chk("abort_nwr",  wa_q.size(), 32'd1);
      if (wa_q.size() == 1) begin
         chk("abort_a0", {26'd0, wa_q[0]}, 32'h10);
         chk("abort_d0", {16'd0, wd_q[0]}, 32'hAABB);
      end
      chk("abort_done", done_cnt - d0, 32'd0);
      // Next frame clears err (checked inside send_frame) and loads normally.
      wa_q.delete(); wd_q.delete(); d0 = done_cnt;
      fr = '{8'h00, 8'h01, 8'h12, 8'h34};
      send_frame(1'b0, 8'h00);
      chk("post_abort_nwr",  wa_q.size(), 32'd1);
      if (wa_q.size() == 1) chk("post_abort_d0", {16'd0, wd_q[0]}, 32'h1234);
      chk("post_abort_done", done_cnt - d0, 32'd1);

      // ---- backpressure: basic frame with random gaps ----
      wa_q.delete(); wd_q.delete(); d0 = done_cnt;
      fr = '{8'h20, 8'h02, 8'h30, 8'h00, 8'h8C, 8'h08};
      send_frame(1'b1, 8'h00);
      chk("bp_nwr", wa_q.size(), 32'd2);
      if (wa_q.size() == 2) begin
         chk("bp_a0", {26'd0, wa_q[0]}, 32'h20);
         chk("bp_d0", {16'd0, wd_q[0]}, 32'h3000);
         chk("bp_a1", {26'd0, wa_q[1]}, 32'h21);
         chk("bp_d1", {16'd0, wd_q[1]}, 32'h8C08);
      end
      chk("bp_done", done_cnt - d0, 32'd1);

      // ---- reset mid-DATA_HI, with a write strobe in flight ----
      wa_q.delete(); wd_q.delete(); d0 = done_cnt;
      send(8'hA5); send(8'h20); send(8'h02); send(8'h30); send(8'h00);
      in_valid = 1'b0;
      rst      = 1'b1;
      cycles(1);
      chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("mid_rst_wr_en",    {31'd0, wr_en},    32'd0);
      chk("mid_rst_hold",     {31'd0, cpu_hold}, 32'd0);
      chk("mid_rst_done",     {31'd0, done},     32'd0);
      chk("mid_rst_err",      {31'd0, err},      32'd0);
      chk("mid_rst_wr_addr",  {26'd0, wr_addr},  32'd0);
      chk("mid_rst_wr_data",  {16'd0, wr_data},  32'd0);
      rst = 1'b0;
      cycles(2);
      chk("mid_rst_nwr",  wa_q.size(), 32'd1);
      chk("mid_rst_ndone", done_cnt - d0, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
